// File: rtl/pp_axi_pkg.sv
// Shared AXI3 encodings and state types for the slave-memory block.
package pp_axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Only full 32-bit beats are supported; any other size is answered with SLVERR.
  localparam logic [2:0] AXI_SIZE_4B     = 3'd2;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_WAIT  = 2'd1,
    R_BURST = 2'd2
  } r_state_e;

  // Map an accumulated error flag to the response code returned on B or R.
  function automatic logic [1:0] axi_resp(input logic err);
    return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/pp_axi_mem_ram.sv
// Word-organised storage: one byte-enabled write port, one combinational read port.
// No reset on the array so contents survive a controller reset.
module pp_axi_mem_ram #(
  parameter int P_AW = 12
) (
  input  logic              clk_core,
  input  logic              i_we,
  input  logic [P_AW-1:0]   i_waddr,
  input  logic [3:0]        i_wbe,
  input  logic [31:0]       i_wdata,
  input  logic [P_AW-1:0]   i_raddr,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [0:(1<<P_AW)-1];

  // Byte-lane write; untouched lanes keep their old value.
  always_ff @(posedge clk_core) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wbe[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pp_axi_slave_mem.sv
// AXI3 slave backed by a local word array; one outstanding write and one
// outstanding read, handled by two independent FSMs.
//
// Write FSM
//   state  | meaning
//   W_IDLE | awready high, waiting for an address
//   W_DATA | wready high, committing beats until beat awlen
//   W_RESP | bvalid held until bready
// Read FSM
//   state   | meaning
//   R_IDLE  | arready high, waiting for an address
//   R_WAIT  | fixed latency gap of P_RLAT cycles
//   R_BURST | rvalid high, one beat per R handshake until beat arlen
module pp_axi_slave_mem
  import pp_axi_pkg::*;
#(
  parameter int P_ID_W   = 4,
  parameter int P_MEM_AW = 12,
  parameter int P_RLAT   = 2
) (
  input  logic              clk_core,
  input  logic              rst_x,
  input  logic [P_ID_W-1:0] i_awid,
  input  logic [31:0]       i_awaddr,
  input  logic [3:0]        i_awlen,
  input  logic [2:0]        i_awsize,
  input  logic [1:0]        i_awburst,
  input  logic              i_awvalid,
  output logic              o_awready,
  input  logic [P_ID_W-1:0] i_wid,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_wstrb,
  input  logic              i_wlast,
  input  logic              i_wvalid,
  output logic              o_wready,
  output logic [P_ID_W-1:0] o_bid,
  output logic [1:0]        o_bresp,
  output logic              o_bvalid,
  input  logic              i_bready,
  input  logic [P_ID_W-1:0] i_arid,
  input  logic [31:0]       i_araddr,
  input  logic [3:0]        i_arlen,
  input  logic [2:0]        i_arsize,
  input  logic [1:0]        i_arburst,
  input  logic              i_arvalid,
  output logic              o_arready,
  output logic [P_ID_W-1:0] o_rid,
  output logic [31:0]       o_rdata,
  output logic [1:0]        o_rresp,
  output logic              o_rlast,
  output logic              o_rvalid,
  input  logic              i_rready
);

  // Latency counter load: counts down to zero, so it is loaded with P_RLAT-1.
  localparam logic [2:0] LP_RLAT_LOAD = (P_RLAT > 0) ? 3'(P_RLAT - 1) : 3'd0;

  // FIXED holds the address; INCR, WRAP and the reserved code all step by one word.
  function automatic logic [P_MEM_AW-1:0] f_next_addr(input logic [P_MEM_AW-1:0] a,
                                                      input logic [1:0] burst);
    return (burst == AXI_BURST_FIXED) ? a : a + P_MEM_AW'(1);
  endfunction

  // ---------------- write side ----------------
  w_state_e            r_w_state;
  logic                r_awready;
  logic                r_wready;
  logic                r_bvalid;
  logic [P_ID_W-1:0]   r_bid;
  logic [1:0]          r_bresp;
  logic [P_MEM_AW-1:0] r_w_addr;
  logic [3:0]          r_w_len;
  logic [3:0]          r_w_cnt;
  logic [1:0]          r_w_burst;
  logic                r_w_err;

  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_w_final;
  logic                w_w_beat_err;
  logic                w_mem_we;

  assign w_aw_hs      = i_awvalid & r_awready;
  assign w_w_hs       = i_wvalid & r_wready;
  assign w_w_final    = (r_w_cnt == r_w_len);
  // A beat is bad if the burst is already in error or wlast disagrees with position.
  assign w_w_beat_err = r_w_err | (i_wlast != w_w_final);
  // Gated by rst_x so a beat landing on the reset edge is dropped with the burst.
  assign w_mem_we     = rst_x & (r_w_state == W_DATA) & w_w_hs & ~w_w_beat_err;

  // Write FSM with registered handshake and response outputs.
  always_ff @(posedge clk_core) begin
    if (!rst_x) begin
      r_w_state <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= '0;
      r_w_addr  <= '0;
      r_w_len   <= '0;
      r_w_cnt   <= '0;
      r_w_burst <= '0;
      r_w_err   <= 1'b0;
    end else begin
      case (r_w_state)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (w_aw_hs) begin
            r_w_state <= W_DATA;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_bid     <= i_awid;
            r_w_addr  <= i_awaddr[P_MEM_AW+1:2];
            r_w_len   <= i_awlen;
            r_w_cnt   <= 4'd0;
            r_w_burst <= i_awburst;
            r_w_err   <= (i_awsize != AXI_SIZE_4B);
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_w_addr <= f_next_addr(r_w_addr, r_w_burst);
            r_w_cnt  <= r_w_cnt + 4'd1;
            if (w_w_beat_err) r_w_err <= 1'b1;
            // The burst length, not wlast, decides where the burst ends.
            if (w_w_final) begin
              r_w_state <= W_RESP;
              r_wready  <= 1'b0;
              r_bvalid  <= 1'b1;
              r_bresp   <= axi_resp(w_w_beat_err);
            end
          end
        end
        W_RESP: begin
          if (i_bready) begin
            r_w_state <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
          end
        end
        default: begin
          r_w_state <= W_IDLE;
          r_awready <= 1'b0;
          r_wready  <= 1'b0;
          r_bvalid  <= 1'b0;
        end
      endcase
    end
  end

  assign o_awready = r_awready;
  assign o_wready  = r_wready;
  assign o_bvalid  = r_bvalid;
  assign o_bid     = r_bid;
  assign o_bresp   = r_bresp;

  // ---------------- read side ----------------
  r_state_e            r_r_state;
  logic                r_arready;
  logic                r_rvalid;
  logic                r_rlast;
  logic [P_ID_W-1:0]   r_rid;
  logic [1:0]          r_rresp;
  logic [31:0]         r_rdata;
  logic [P_MEM_AW-1:0] r_r_addr;
  logic [3:0]          r_r_len;
  logic [3:0]          r_r_cnt;
  logic [1:0]          r_r_burst;
  logic                r_r_err;
  logic [2:0]          r_r_tmr;

  logic                w_ar_hs;
  logic                w_r_hs;
  logic                w_ar_err;
  logic [P_MEM_AW-1:0] w_r_addr_next;
  logic [P_MEM_AW-1:0] w_ram_raddr;
  logic [31:0]         w_ram_rdata;

  assign w_ar_hs       = i_arvalid & r_arready;
  assign w_r_hs        = r_rvalid & i_rready;
  assign w_ar_err      = (i_arsize != AXI_SIZE_4B);
  assign w_r_addr_next = f_next_addr(r_r_addr, r_r_burst);

  // Read port points at the word that will be presented on the next R beat,
  // so rdata can be registered and stays put while the master stalls.
  always_comb begin
    w_ram_raddr = r_r_addr;
    case (r_r_state)
      R_IDLE:  w_ram_raddr = i_araddr[P_MEM_AW+1:2];
      R_WAIT:  w_ram_raddr = r_r_addr;
      R_BURST: w_ram_raddr = w_r_addr_next;
      default: w_ram_raddr = r_r_addr;
    endcase
  end

  // Read FSM with registered R channel; data is forced to zero on SLVERR.
  always_ff @(posedge clk_core) begin
    if (!rst_x) begin
      r_r_state <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_rresp   <= '0;
      r_rdata   <= '0;
      r_r_addr  <= '0;
      r_r_len   <= '0;
      r_r_cnt   <= '0;
      r_r_burst <= '0;
      r_r_err   <= 1'b0;
      r_r_tmr   <= '0;
    end else begin
      case (r_r_state)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rid     <= i_arid;
            r_rresp   <= axi_resp(w_ar_err);
            r_r_addr  <= i_araddr[P_MEM_AW+1:2];
            r_r_len   <= i_arlen;
            r_r_cnt   <= 4'd0;
            r_r_burst <= i_arburst;
            r_r_err   <= w_ar_err;
            r_r_tmr   <= LP_RLAT_LOAD;
            if (P_RLAT == 0) begin
              r_r_state <= R_BURST;
              r_rvalid  <= 1'b1;
              r_rlast   <= (i_arlen == 4'd0);
              r_rdata   <= w_ar_err ? 32'd0 : w_ram_rdata;
            end else begin
              r_r_state <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (r_r_tmr == 3'd0) begin
            r_r_state <= R_BURST;
            r_rvalid  <= 1'b1;
            r_rlast   <= (r_r_len == 4'd0);
            r_rdata   <= r_r_err ? 32'd0 : w_ram_rdata;
          end else begin
            r_r_tmr <= r_r_tmr - 3'd1;
          end
        end
        R_BURST: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_r_state <= R_IDLE;
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
            end else begin
              r_r_addr <= w_r_addr_next;
              r_r_cnt  <= r_r_cnt + 4'd1;
              r_rlast  <= ((r_r_cnt + 4'd1) == r_r_len);
              r_rdata  <= r_r_err ? 32'd0 : w_ram_rdata;
            end
          end
        end
        default: begin
          r_r_state <= R_IDLE;
          r_arready <= 1'b0;
          r_rvalid  <= 1'b0;
          r_rlast   <= 1'b0;
        end
      endcase
    end
  end

  assign o_arready = r_arready;
  assign o_rvalid  = r_rvalid;
  assign o_rlast   = r_rlast;
  assign o_rid     = r_rid;
  assign o_rresp   = r_rresp;
  assign o_rdata   = r_rdata;

  // ---------------- storage ----------------
  pp_axi_mem_ram #(
    .P_AW (P_MEM_AW)
  ) u_ram (
    .clk_core (clk_core),
    .i_we     (w_mem_we),
    .i_waddr  (r_w_addr),
    .i_wbe    (i_wstrb),
    .i_wdata  (i_wdata),
    .i_raddr  (w_ram_raddr),
    .o_rdata  (w_ram_rdata)
  );

  // WID and the address bits outside the word index carry no meaning here.
  logic w_unused;
  assign w_unused = ^{i_wid, i_awaddr[31:P_MEM_AW+2], i_awaddr[1:0],
                      i_araddr[31:P_MEM_AW+2], i_araddr[1:0]};

endmodule

// File: tb/tb_pp_axi_slave_mem.sv
// Testbench for pp_axi_slave_mem: table of AXI transactions checked against a
// word-array model, with expected B/R responses queued at stimulus time.
module tb_pp_axi_slave_mem;
  import pp_axi_pkg::*;

  localparam int P_ID_W   = 4;
  localparam int P_MEM_AW = 12;
  localparam int P_RLAT   = 2;

  logic              clk_core = 1'b0;
  logic              rst_x;
  logic [P_ID_W-1:0] i_awid;
  logic [31:0]       i_awaddr;
  logic [3:0]        i_awlen;
  logic [2:0]        i_awsize;
  logic [1:0]        i_awburst;
  logic              i_awvalid;
  logic              o_awready;
  logic [P_ID_W-1:0] i_wid;
  logic [31:0]       i_wdata;
  logic [3:0]        i_wstrb;
  logic              i_wlast;
  logic              i_wvalid;
  logic              o_wready;
  logic [P_ID_W-1:0] o_bid;
  logic [1:0]        o_bresp;
  logic              o_bvalid;
  logic              i_bready;
  logic [P_ID_W-1:0] i_arid;
  logic [31:0]       i_araddr;
  logic [3:0]        i_arlen;
  logic [2:0]        i_arsize;
  logic [1:0]        i_arburst;
  logic              i_arvalid;
  logic              o_arready;
  logic [P_ID_W-1:0] o_rid;
  logic [31:0]       o_rdata;
  logic [1:0]        o_rresp;
  logic              o_rlast;
  logic              o_rvalid;
  logic              i_rready;

  always #5 clk_core = ~clk_core;

  pp_axi_slave_mem #(
    .P_ID_W   (P_ID_W),
    .P_MEM_AW (P_MEM_AW),
    .P_RLAT   (P_RLAT)
  ) dut (
    .clk_core  (clk_core),
    .rst_x     (rst_x),
    .i_awid    (i_awid),
    .i_awaddr  (i_awaddr),
    .i_awlen   (i_awlen),
    .i_awsize  (i_awsize),
    .i_awburst (i_awburst),
    .i_awvalid (i_awvalid),
    .o_awready (o_awready),
    .i_wid     (i_wid),
    .i_wdata   (i_wdata),
    .i_wstrb   (i_wstrb),
    .i_wlast   (i_wlast),
    .i_wvalid  (i_wvalid),
    .o_wready  (o_wready),
    .o_bid     (o_bid),
    .o_bresp   (o_bresp),
    .o_bvalid  (o_bvalid),
    .i_bready  (i_bready),
    .i_arid    (i_arid),
    .i_araddr  (i_araddr),
    .i_arlen   (i_arlen),
    .i_arsize  (i_arsize),
    .i_arburst (i_arburst),
    .i_arvalid (i_arvalid),
    .o_arready (o_arready),
    .o_rid     (o_rid),
    .o_rdata   (o_rdata),
    .o_rresp   (o_rresp),
    .o_rlast   (o_rlast),
    .o_rvalid  (o_rvalid),
    .i_rready  (i_rready)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [31:0] dbase;
    logic [3:0]  strb;
    int          bad;       // write beat whose wlast is flipped, -1 for none
    bit          toggle;    // reads: toggle rready every cycle
    logic [1:0]  exp_resp;
  } vec_t;

  typedef struct {
    logic [P_ID_W-1:0] id;
    logic [31:0]       data;
    logic [1:0]        resp;
    logic              last;
  } rexp_t;

  typedef struct {
    logic [P_ID_W-1:0] id;
    logic [1:0]        resp;
  } bexp_t;

  rexp_t       r_q[$];
  bexp_t       b_q[$];
  logic [31:0] mdl [4096];
  int          n_cmp = 0;
  int          n_err = 0;
  time         t_aw;
  time         t_ar;
  vec_t        vt [19];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endfunction

  function automatic void fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout/empty required handshake", nm);
  endfunction

  function automatic logic [11:0] nxt(input logic [11:0] a, input logic [1:0] b);
    return (b == AXI_BURST_FIXED) ? a : a + 12'd1;
  endfunction

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic send_aw(input vec_t v, input logic [P_ID_W-1:0] id, output bit ok);
    int bud = 50;
    bit hs;
    i_awid = id; i_awaddr = v.addr; i_awlen = v.len; i_awburst = v.burst;
    i_awsize = v.size; i_awvalid = 1'b1;
    do begin hs = o_awready; step(); bud--; end while (!hs && bud > 0);
    i_awvalid = 1'b0;
    t_aw = $time;
    ok = hs;
    if (!hs) fail("aw_timeout");
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic l, output bit ok);
    int bud = 50;
    bit hs;
    i_wdata = d; i_wstrb = s; i_wlast = l; i_wvalid = 1'b1;
    do begin hs = o_wready; step(); bud--; end while (!hs && bud > 0);
    i_wvalid = 1'b0; i_wlast = 1'b0;
    ok = hs;
    if (!hs) fail("w_timeout");
  endtask

  task automatic do_write(input vec_t v, input logic [P_ID_W-1:0] id);
    bit ok;
    bit err;
    int bud = 50;
    bexp_t e;
    logic [11:0] wa;
    b_q.push_back('{id, v.exp_resp});
    send_aw(v, id, ok);
    if (!ok) return;
    err = (v.size != AXI_SIZE_4B);
    wa = v.addr[13:2];
    for (int i = 0; i <= int'(v.len); i++) begin
      if (i == v.bad) err = 1'b1;
      send_w(v.dbase + 32'(i), v.strb, ((i == int'(v.len)) ^ (i == v.bad)), ok);
      if (!ok) return;
      if (!err)
        for (int b = 0; b < 4; b++)
          if (v.strb[b]) mdl[wa][8*b +: 8] = (v.dbase + 32'(i)) >> (8*b);
      wa = nxt(wa, v.burst);
    end
    i_bready = 1'b0;
    while (!o_bvalid && bud > 0) begin step(); bud--; end
    if (!o_bvalid) begin fail("b_timeout"); return; end
    step();
    chk("b_hold", o_bvalid, 1);
    i_bready = 1'b1;
    if (b_q.size() == 0) begin fail("b_q_empty"); return; end
    e = b_q.pop_front();
    chk("bid", o_bid, e.id);
    chk("bresp", o_bresp, e.resp);
    step();
    i_bready = 1'b0;
    chk("b_clear", o_bvalid, 0);
  endtask

  task automatic do_read(input vec_t v, input logic [P_ID_W-1:0] id);
    int n = int'(v.len) + 1;
    int got = 0;
    int gap = 0;
    int bud = 200;
    bit seen = 0;
    bit stalled = 0;
    bit hs;
    logic [31:0] hold_d;
    logic [11:0] wa = v.addr[13:2];
    rexp_t e;
    for (int i = 0; i < n; i++) begin
      e.id = id;
      e.resp = v.exp_resp;
      e.data = (v.exp_resp == AXI_RESP_OKAY) ? mdl[wa] : 32'd0;
      e.last = (i == n - 1);
      r_q.push_back(e);
      wa = nxt(wa, v.burst);
    end
    i_arid = id; i_araddr = v.addr; i_arlen = v.len; i_arburst = v.burst;
    i_arsize = v.size; i_arvalid = 1'b1; i_rready = 1'b1;
    do begin hs = o_arready; step(); bud--; end while (!hs && bud > 0);
    i_arvalid = 1'b0;
    t_ar = $time;
    if (!hs) begin fail("ar_timeout"); return; end
    while (got < n && bud > 0) begin
      if (o_rvalid) begin
        if (!seen) begin seen = 1; chk("r_latency", gap, P_RLAT); end
        if (stalled) chk("r_stall_stable", o_rdata, hold_d);
        if (i_rready) begin
          if (r_q.size() == 0) begin fail("r_q_empty"); return; end
          e = r_q.pop_front();
          chk("rdata", o_rdata, e.data);
          chk("rresp", o_rresp, e.resp);
          chk("rlast", o_rlast, e.last);
          chk("rid", o_rid, e.id);
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          hold_d = o_rdata;
        end
      end else if (!seen) gap++;
      step();
      bud--;
      if (v.toggle) i_rready = ~i_rready;
    end
    i_rready = 1'b0;
    if (got < n) begin fail("r_timeout"); return; end
    chk("r_clear", o_rvalid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit required finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    vec_t v;
    rst_x = 1'b0;
    i_awid = '0; i_awaddr = '0; i_awlen = '0; i_awsize = '0; i_awburst = '0; i_awvalid = 1'b0;
    i_wid = '0; i_wdata = '0; i_wstrb = '0; i_wlast = 1'b0; i_wvalid = 1'b0; i_bready = 1'b0;
    i_arid = '0; i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arburst = '0; i_arvalid = 1'b0;
    i_rready = 1'b0;
    for (int i = 0; i < 4096; i++) mdl[i] = 32'd0;

    repeat (3) step();
    chk("rst_awready", o_awready, 0);
    chk("rst_arready", o_arready, 0);
    chk("rst_wready", o_wready, 0);
    chk("rst_bvalid", o_bvalid, 0);
    chk("rst_rvalid", o_rvalid, 0);
    chk("rst_rlast", o_rlast, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_bid_rid", {o_bid, o_rid}, 0);
    chk("rst_bresp_rresp", {o_bresp, o_rresp}, 0);
    rst_x = 1'b1;
    step();
    chk("post_rst_awready", o_awready, 1);
    chk("post_rst_arready", o_arready, 1);

    //         wr    addr        len   burst            size  dbase         strb  bad tog resp
    vt[0]  = '{1'b1, 32'h100,  4'd3, AXI_BURST_INCR,  3'd2, 32'hA0,       4'hF, -1, 1'b0, AXI_RESP_OKAY};
    vt[1]  = '{1'b0, 32'h100,  4'd3, AXI_BURST_INCR,  3'd2, 32'h0,        4'h0, -1, 1'b0, AXI_RESP_OKAY};
    vt[2]  = '{1'b1, 32'h110,  4'd3, AXI_BURST_INCR,  3'd2, 32'hB0,       4'hF, -1, 1'b0, AXI_RESP_OKAY};
    vt[3]  = '{1'b0, 32'h100,  4'd7, AXI_BURST_INCR,  3'd2, 32'h0,        4'h0, -1, 1'b1, AXI_RESP_OKAY};
    vt[4]  = '{1'b1, 32'h200,  4'd0, AXI_BURST_INCR,  3'd2, 32'h0,        4'hF, -1, 1'b0, AXI_RESP_OKAY};
    vt[5]  = '{1'b1, 32'h200,  4'd0, AXI_BURST_INCR,  3'd2, 32'hDEADBEEF, 4'h5, -1, 1'b0, AXI_RESP_OKAY};
    vt[6]  = '{1'b0, 32'h200,  4'd0, AXI_BURST_INCR,  3'd2, 32'h0,        4'h0, -1, 1'b0, AXI_RESP_OKAY};
    vt[7]  = '{1'b1, 32'h300,  4'd2, AXI_BURST_INCR,  3'd2, 32'h0,        4'hF, -1, 1'b0, AXI_RESP_OKAY};
    vt[8]  = '{1'b1, 32'h300,  4'd2, AXI_BURST_INCR,  3'd2, 32'hE0,       4'hF,  1, 1'b0, AXI_RESP_SLVERR};
    vt[9]  = '{1'b0, 32'h300,  4'd2, AXI_BURST_INCR,  3'd2, 32'h0,        4'h0, -1, 1'b0, AXI_RESP_OKAY};
    vt[10] = '{1'b1, 32'h500,  4'd2, AXI_BURST_FIXED, 3'd2, 32'hF0,       4'hF, -1, 1'b0, AXI_RESP_OKAY};
    vt[11] = '{1'b0, 32'h500,  4'd1, AXI_BURST_FIXED, 3'd2, 32'h0,        4'h0, -1, 1'b0, AXI_RESP_OKAY};
    vt[12] = '{1'b1, 32'h3FFC, 4'd1, AXI_BURST_INCR,  3'd2, 32'h11,       4'hF, -1, 1'b0, AXI_RESP_OKAY};
    vt[13] = '{1'b0, 32'h3FFC, 4'd1, AXI_BURST_INCR,  3'd2, 32'h0,        4'h0, -1, 1'b1, AXI_RESP_OKAY};
    vt[14] = '{1'b1, 32'h600,  4'd1, AXI_BURST_INCR,  3'd1, 32'h77,       4'hF, -1, 1'b0, AXI_RESP_SLVERR};
    vt[15] = '{1'b0, 32'h600,  4'd1, AXI_BURST_INCR,  3'd1, 32'h0,        4'h0, -1, 1'b0, AXI_RESP_SLVERR};
    vt[16] = '{1'b1, 32'h700,  4'd1, AXI_BURST_WRAP,  3'd2, 32'h55,       4'hF, -1, 1'b0, AXI_RESP_OKAY};
    vt[17] = '{1'b0, 32'h700,  4'd1, AXI_BURST_WRAP,  3'd2, 32'h0,        4'h0, -1, 1'b0, AXI_RESP_OKAY};
    vt[18] = '{1'b1, 32'h400,  4'd3, AXI_BURST_INCR,  3'd2, 32'h0,        4'hF, -1, 1'b0, AXI_RESP_OKAY};

    for (int k = 0; k < 19; k++) begin
      if (vt[k].wr) do_write(vt[k], 4'(k));
      else          do_read(vt[k], 4'(k));
    end

    // AW and AR presented together: both must be taken on the same edge.
    fork
      do_write('{1'b1, 32'h800, 4'd1, AXI_BURST_INCR, 3'd2, 32'hD0, 4'hF, -1, 1'b0, AXI_RESP_OKAY}, 4'hC);
      do_read ('{1'b0, 32'h100, 4'd3, AXI_BURST_INCR, 3'd2, 32'h0,  4'h0, -1, 1'b1, AXI_RESP_OKAY}, 4'hD);
    join
    chk("aw_ar_same_edge", 32'(t_ar - t_aw), 0);
    do_read('{1'b0, 32'h800, 4'd1, AXI_BURST_INCR, 3'd2, 32'h0, 4'h0, -1, 1'b0, AXI_RESP_OKAY}, 4'hE);

    // Reset during the third beat of a 4-beat write: burst dropped, no B.
    v = '{1'b1, 32'h400, 4'd3, AXI_BURST_INCR, 3'd2, 32'hC0, 4'hF, -1, 1'b0, AXI_RESP_OKAY};
    send_aw(v, 4'h5, ok);
    for (int i = 0; i < 2; i++) begin
      send_w(32'hC0 + 32'(i), 4'hF, 1'b0, ok);
      mdl[12'h100 + 12'(i)] = 32'hC0 + 32'(i);
    end
    i_wdata = 32'hC2; i_wstrb = 4'hF; i_wlast = 1'b0; i_wvalid = 1'b1;
    rst_x = 1'b0;
    step();
    i_wvalid = 1'b0;
    step();
    chk("rst_mid_bvalid", o_bvalid, 0);
    chk("rst_mid_awready", o_awready, 0);
    chk("rst_mid_wready", o_wready, 0);
    rst_x = 1'b1;
    step();
    chk("rst_rel_awready", o_awready, 1);
    chk("rst_rel_wready", o_wready, 0);
    for (int i = 0; i < 3; i++) begin
      chk("no_b_after_abort", o_bvalid, 0);
      step();
    end
    do_read('{1'b0, 32'h400, 4'd3, AXI_BURST_INCR, 3'd2, 32'h0, 4'h0, -1, 1'b0, AXI_RESP_OKAY}, 4'h6);
    do_write('{1'b1, 32'h408, 4'd0, AXI_BURST_INCR, 3'd2, 32'h99, 4'hF, -1, 1'b0, AXI_RESP_OKAY}, 4'h7);
    do_read('{1'b0, 32'h400, 4'd3, AXI_BURST_INCR, 3'd2, 32'h0, 4'h0, -1, 1'b1, AXI_RESP_OKAY}, 4'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
